// File: rtl/serial_addsub_ctrl_if.sv
// Handshake bundle for the bit-serial add/subtract sequencer: an operand
// channel in, a result channel out, plus the busy status flag.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder bit per clock, LSB first,
// with valid/ready handshakes on the operand and result channels.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            reset,
  serial_addsub_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_carryOut;
  logic             r_overflow;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;

  logic             w_sum;
  logic             w_carryNext;
  logic             w_lastBit;

  assign w_sum       = r_aShift[0] ^ r_bShift[0] ^ r_carry;
  assign w_carryNext = (r_aShift[0] & r_bShift[0]) |
                       (r_aShift[0] & r_carry)     |
                       (r_bShift[0] & r_carry);
  assign w_lastBit   = (r_count == CNT_W'(WIDTH - 1));

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_aShift   <= bus.a;
            r_bShift   <= bus.op_sub ? ~bus.b : bus.b;
            r_carry    <= bus.op_sub;
            r_count    <= '0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
            r_overflow <= 1'b0;
            r_inReady  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          r_carry  <= w_carryNext;
          r_aShift <= r_aShift >> 1;
          r_bShift <= r_bShift >> 1;
          r_result <= {w_sum, r_result[WIDTH-1:1]};
          r_count  <= r_count + CNT_W'(1);
          // On the MSB, r_carry is the carry into the MSB and w_carryNext the carry out.
          if (w_lastBit) begin
            r_carryOut <= w_carryNext;
            r_overflow <= r_carry ^ w_carryNext;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carryOut;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vector table, hold/ignore
// and mid-operation reset sequences, then a randomized regression against a golden model.
module tb_serial_addsub_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] expResult;
    logic       expCo;
    logic       expOv;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present operands until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic op);
    int waitCycles;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = op;
    bus.in_valid = 1'b1;
    waitCycles   = 0;
    while (!bus.in_ready && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'(~a);
    bus.b        = 8'(~b);
    bus.op_sub   = ~op;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finishOp();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int lat;
    applyStimulus(v.a, v.b, v.op);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    checkOutput({tag, "_result"}, 32'(bus.result), 32'(v.expResult));
    checkOutput({tag, "_carry"}, 32'(bus.carry_out), 32'(v.expCo));
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(v.expOv));
    finishOp();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    int         extraValid;
    int         expSum;
    logic [7:0] holdResult;
    logic       holdCo;
    logic       holdOv;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rop;
    logic [7:0] gResult;
    logic       gCo;
    logic       gOv;

    nChecks = 0;
    nFails  = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h03, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_result", 32'(bus.result), 32'd0);
    checkOutput("reset_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);

    for (int i = 0; i < 10; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
      checkOutput($sformatf("vec%0d_ready_after", i), 32'(bus.in_ready), 32'd1);
    end

    // Hold DONE with out_ready low and pulse in_valid during SHIFT and DONE.
    applyStimulus(8'h3C, 8'h21, 1'b0);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.op_sub = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_busy_shift", 32'(bus.busy), 32'd1);
    checkOutput("hold_in_ready_shift", 32'(bus.in_ready), 32'd0);
    waitResult(lat);
    checkOutput("hold_latency", 32'(lat + 1), 32'(WIDTH));
    holdResult = bus.result;
    holdCo     = bus.carry_out;
    holdOv     = bus.overflow;
    checkOutput("hold_result", 32'(holdResult), 32'h5D);
    checkOutput("hold_carry", 32'(holdCo), 32'd0);
    checkOutput("hold_overflow", 32'(holdOv), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_busy_done", 32'(bus.busy), 32'd1);
      checkOutput("hold_result_stable", 32'(bus.result), 32'(holdResult));
      checkOutput("hold_carry_stable", 32'(bus.carry_out), 32'(holdCo));
      checkOutput("hold_overflow_stable", 32'(bus.overflow), 32'(holdOv));
    end
    bus.in_valid = 1'b0;
    finishOp();
    checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("release_busy", 32'(bus.busy), 32'd0);
    extraValid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) extraValid++;
    end
    checkOutput("no_second_result", 32'(extraValid), 32'd0);
    checkOutput("idle_result_kept", 32'(bus.result), 32'h5D);

    // Abandon an operation with reset while bit 4 is being processed.
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_result", 32'(bus.result), 32'd0);
    checkOutput("midreset_carry", 32'(bus.carry_out), 32'd0);
    checkOutput("midreset_overflow", 32'(bus.overflow), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("postreset_in_ready", 32'(bus.in_ready), 32'd1);
    runVector("postreset", '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0});

    // Randomized regression against an arithmetic golden model.
    for (int n = 0; n < 2000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 1'($urandom);
      if (rop) begin
        expSum = int'($signed(ra)) - int'($signed(rb));
        gResult = 8'(int'(ra) - int'(rb));
        gCo     = (ra >= rb);
      end else begin
        expSum = int'($signed(ra)) + int'($signed(rb));
        gResult = 8'(int'(ra) + int'(rb));
        gCo     = (int'(ra) + int'(rb)) > 255;
      end
      gOv = (expSum > 127) || (expSum < -128);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      applyStimulus(ra, rb, rop);
      waitResult(lat);
      checkOutput("rand_latency", 32'(lat), 32'(WIDTH));
      checkOutput("rand_result", 32'(bus.result), 32'(gResult));
      checkOutput("rand_carry", 32'(bus.carry_out), 32'(gCo));
      checkOutput("rand_overflow", 32'(bus.overflow), 32'(gOv));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      finishOp();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
